// File: rtl/hamming_scrub_ctrl.sv
// Background scrubber for a Hamming(7,4) codeword RAM: reads each word, writes back
// single-bit corrections, tracks error statistics and yields the port to a host.
module hamming_scrub_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int INTERVAL = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              host_req,
  output logic              host_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [6:0]        mem_wdata,
  input  logic [6:0]        mem_rdata,
  output logic              busy,
  output logic              pass_done,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] last_err_addr
);

  localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);

  typedef enum logic [2:0] {IDLE, WAIT, RD, CHK, WB, HOST} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              host_gnt_q, host_gnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [6:0]        mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              pass_done_q, pass_done_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [ADDR_W-1:0] last_err_addr_q, last_err_addr_d;

  logic [2:0]        syn;
  logic [6:0]        fixed_word;
  logic              word_done;

  always_comb begin
    syn[0] = mem_rdata[0] ^ mem_rdata[2] ^ mem_rdata[4] ^ mem_rdata[6];
    syn[1] = mem_rdata[1] ^ mem_rdata[2] ^ mem_rdata[5] ^ mem_rdata[6];
    syn[2] = mem_rdata[3] ^ mem_rdata[4] ^ mem_rdata[5] ^ mem_rdata[6];
    fixed_word = (syn == 3'd0) ? mem_rdata : (mem_rdata ^ (7'd1 << (syn - 3'd1)));
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    err_count_d     = err_count_q;
    last_err_addr_d = last_err_addr_q;
    word_done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (host_req) begin
          state_d = HOST;
        end else if (enable) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      // Host takes priority over both a disable and a simultaneous expiry.
      WAIT: begin
        if (host_req) begin
          state_d = HOST;
        end else if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD: state_d = CHK;
      CHK: begin
        if (syn != 3'd0) state_d = WB;
        else             word_done = 1'b1;
      end
      WB: begin
        word_done       = 1'b1;
        last_err_addr_d = ptr_q;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
      HOST: begin
        if (!host_req) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase

    // A finished word always advances the pointer and restarts the interval.
    if (word_done) begin
      ptr_d = ptr_q + ADDR_W'(1);
      cnt_d = '0;
      if (host_req)    state_d = HOST;
      else if (enable) state_d = WAIT;
      else             state_d = IDLE;
    end

    pass_done_d = word_done && (ptr_q == '1);
    host_gnt_d  = (state_d == HOST);
    mem_en_d    = (state_d == RD) || (state_d == WB);
    mem_we_d    = (state_d == WB);
    mem_addr_d  = mem_en_d ? ptr_d : '0;
    mem_wdata_d = (state_d == WB) ? fixed_word : 7'd0;
    busy_d      = (state_d == RD) || (state_d == CHK) || (state_d == WB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      ptr_q           <= '0;
      host_gnt_q      <= 1'b0;
      mem_en_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= 7'd0;
      busy_q          <= 1'b0;
      pass_done_q     <= 1'b0;
      err_count_q     <= 8'd0;
      last_err_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
      host_gnt_q      <= host_gnt_d;
      mem_en_q        <= mem_en_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      pass_done_q     <= pass_done_d;
      err_count_q     <= err_count_d;
      last_err_addr_q <= last_err_addr_d;
    end
  end

  assign host_gnt      = host_gnt_q;
  assign mem_en        = mem_en_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign pass_done     = pass_done_q;
  assign err_count     = err_count_q;
  assign last_err_addr = last_err_addr_q;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// Bench for hamming_scrub_ctrl: a behavioural codeword RAM plus a queue of expected
// corrective writes filled whenever a word is corrupted.
module tb_hamming_scrub_ctrl;

  localparam int ADDR_W   = 4;
  localparam int INTERVAL = 16;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              host_req;
  logic              host_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [6:0]        mem_wdata;
  logic [6:0]        mem_rdata;
  logic              busy;
  logic              pass_done;
  logic [7:0]        err_count;
  logic [ADDR_W-1:0] last_err_addr;

  logic [6:0]          mem [DEPTH];
  logic [ADDR_W+6:0]   exp_q [$];
  logic                rd_pend;
  logic [ADDR_W-1:0]   rd_pend_addr;
  logic                rd_seen, wr_seen, pd_seen;
  logic [ADDR_W-1:0]   rd_addr;
  int                  checks = 0;
  int                  errors = 0;

  hamming_scrub_ctrl #(.ADDR_W(ADDR_W), .INTERVAL(INTERVAL)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .host_req(host_req),
    .host_gnt(host_gnt), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .pass_done(pass_done), .err_count(err_count), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  // One clock of the RAM model; read data appears for the whole cycle after the strobe.
  task automatic step();
    logic [ADDR_W+6:0] exp;
    @(posedge clk);
    #1;
    mem_rdata = rd_pend ? mem[rd_pend_addr] : 7'b0000001;
    rd_pend = 1'b0;
    rd_seen = 1'b0;
    wr_seen = 1'b0;
    pd_seen = pass_done;
    if (mem_en && !mem_we) begin
      rd_pend      = 1'b1;
      rd_pend_addr = mem_addr;
      rd_seen      = 1'b1;
      rd_addr      = mem_addr;
    end
    if (mem_en && mem_we) begin
      wr_seen = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got addr=%0d data=%b, expected no write", mem_addr, mem_wdata);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp) begin
          errors++;
          $display("[TB] FAIL write got addr=%0d data=%b, expected addr=%0d data=%b",
                   mem_addr, mem_wdata, exp[ADDR_W+6:7], exp[6:0]);
        end
      end
      mem[mem_addr] = mem_wdata;
    end
    if (host_gnt) begin
      checks++;
      if (mem_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL access_while_granted got mem_en=%b, expected 0", mem_en);
      end
    end
  endtask

  task automatic run_until_read(input int budget, output int cyc);
    cyc = 0;
    rd_seen = 1'b0;
    while (cyc < budget && !rd_seen) begin
      step();
      cyc++;
    end
    if (!rd_seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL read_timeout got no read in %0d cycles, expected a read", budget);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout got %0d pending writes, expected 0", exp_q.size());
    end
    step();
    step();
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    enable    = 1'b0;
    host_req  = 1'b0;
    rd_pend   = 1'b0;
    mem_rdata = 7'b0000001;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic preload_clean();
    for (int i = 0; i < DEPTH; i++) mem[i] = encode(4'($urandom_range(0, 15)));
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({host_gnt, mem_en, mem_we, busy, pass_done} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL %s_ctrl got gnt/en/we/busy/pd=%b, expected 00000", tag,
               {host_gnt, mem_en, mem_we, busy, pass_done});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("[TB] FAIL %s_mem got addr=%0d wdata=%b, expected 0", tag, mem_addr, mem_wdata);
    end
    checks++;
    if ({err_count, last_err_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL %s_stats got err_count=%0d last_err_addr=%0d, expected 0", tag,
               err_count, last_err_addr);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    check_all_zero("reset");
  endtask

  task automatic test_clean_word();
    int cyc;
    reset_dut();
    preload_clean();
    mem[0] = 7'b0101101;
    enable = 1'b1;
    run_until_read(40, cyc);
    checks++;
    if (rd_addr !== 4'd0 || cyc != INTERVAL + 1) begin
      errors++;
      $display("[TB] FAIL first_read got addr=%0d after %0d, expected addr=0 after %0d", rd_addr, cyc, INTERVAL + 1);
    end
    run_until_read(40, cyc);
    checks++;
    if (rd_addr !== 4'd1 || cyc != INTERVAL + 2) begin
      errors++;
      $display("[TB] FAIL clean_spacing got addr=%0d gap=%0d, expected addr=1 gap=%0d", rd_addr, cyc, INTERVAL + 2);
    end
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("[TB] FAIL clean_err_count got %0d, expected 0", err_count);
    end
  endtask

  task automatic test_correct();
    int cyc;
    reset_dut();
    preload_clean();
    mem[3] = 7'b0111101;
    exp_q.push_back({4'd3, 7'b0101101});
    enable = 1'b1;
    for (int i = 0; i < 4; i++) run_until_read(40, cyc);
    checks++;
    if (rd_addr !== 4'd3) begin
      errors++;
      $display("[TB] FAIL fourth_read got addr=%0d, expected 3", rd_addr);
    end
    run_until_read(40, cyc);
    checks++;
    if (rd_addr !== 4'd4 || cyc != INTERVAL + 3) begin
      errors++;
      $display("[TB] FAIL fix_spacing got addr=%0d gap=%0d, expected addr=4 gap=%0d", rd_addr, cyc, INTERVAL + 3);
    end
    checks++;
    if (exp_q.size() != 0 || err_count !== 8'd1 || last_err_addr !== 4'd3) begin
      errors++;
      $display("[TB] FAIL fix_stats got pending=%0d err_count=%0d last=%0d, expected 0/1/3",
               exp_q.size(), err_count, last_err_addr);
    end
  endtask

  task automatic test_pass_done();
    int reads = 0, pd = 0, last = -1, n = 0;
    reset_dut();
    preload_clean();
    enable = 1'b1;
    while (reads < 2 * DEPTH + 1 && n < 900) begin
      step();
      n++;
      if (pd_seen) begin
        pd++;
        checks++;
        if (last != DEPTH - 1) begin
          errors++;
          $display("[TB] FAIL pass_done_addr got last read=%0d, expected %0d", last, DEPTH - 1);
        end
      end
      if (rd_seen) begin
        checks++;
        if (rd_addr !== 4'(reads % DEPTH)) begin
          errors++;
          $display("[TB] FAIL read_order got addr=%0d, expected %0d", rd_addr, reads % DEPTH);
        end
        last = int'(rd_addr);
        reads++;
      end
    end
    checks++;
    if (pd != 2 || reads != 2 * DEPTH + 1) begin
      errors++;
      $display("[TB] FAIL pass_count got pulses=%0d reads=%0d, expected 2 and %0d", pd, reads, 2 * DEPTH + 1);
    end
  endtask

  task automatic test_host();
    int cyc, k;
    reset_dut();
    preload_clean();
    enable = 1'b1;
    run_until_read(40, cyc);
    host_req = 1'b1;
    k = 0;
    while (!host_gnt && k < 3) begin
      step();
      k++;
    end
    checks++;
    if (host_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL grant_latency got host_gnt=%b after %0d, expected 1 within 3", host_gnt, k);
    end
    repeat (10) step();
    checks++;
    if (host_gnt !== 1'b1) begin
      errors++;
      $display("[TB] FAIL grant_hold got %b, expected 1", host_gnt);
    end
    host_req = 1'b0;
    step();
    checks++;
    if (host_gnt !== 1'b0) begin
      errors++;
      $display("[TB] FAIL grant_release got %b, expected 0", host_gnt);
    end
    run_until_read(40, cyc);
    checks++;
    if (rd_addr !== 4'd1 || cyc != INTERVAL) begin
      errors++;
      $display("[TB] FAIL host_resume got addr=%0d gap=%0d, expected addr=1 gap=%0d", rd_addr, cyc, INTERVAL);
    end
  endtask

  task automatic test_saturate();
    logic [6:0] clean;
    reset_dut();
    preload_clean();
    for (int p = 0; p < 16; p++) begin
      enable = 1'b0;
      repeat (3) step();
      for (int i = 0; i < DEPTH; i++) begin
        clean  = mem[i];
        mem[i] = clean ^ (7'd1 << $urandom_range(0, 6));
        exp_q.push_back({4'(i), clean});
      end
      enable = 1'b1;
      drain(500);
      if (p == 0) begin
        checks++;
        if (err_count !== 8'd16) begin
          errors++;
          $display("[TB] FAIL first_pass_count got %0d, expected 16", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("[TB] FAIL saturate got %0d, expected 255", err_count);
    end
  endtask

  task automatic test_reset_mid_wb();
    int cyc, n;
    reset_dut();
    preload_clean();
    mem[2] = mem[2] ^ 7'b1000000;
    exp_q.push_back({4'd2, mem[2] ^ 7'b1000000});
    enable = 1'b1;
    n = 0;
    wr_seen = 1'b0;
    while (!wr_seen && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (!wr_seen) begin
      errors++;
      $display("[TB] FAIL wb_timeout got no write, expected one");
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    mem[2] = mem[2] ^ 7'b1000000;
    exp_q.delete();
    exp_q.push_back({4'd2, mem[2] ^ 7'b1000000});
    rd_pend = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run_until_read(40, cyc);
    checks++;
    if (rd_addr !== 4'd0 || cyc != INTERVAL + 1) begin
      errors++;
      $display("[TB] FAIL restart got addr=%0d after %0d, expected addr=0 after %0d", rd_addr, cyc, INTERVAL + 1);
    end
    drain(200);
    checks++;
    if (err_count !== 8'd1 || last_err_addr !== 4'd2) begin
      errors++;
      $display("[TB] FAIL restart_stats got err_count=%0d last=%0d, expected 1/2", err_count, last_err_addr);
    end
  endtask

  initial begin
    test_reset();
    test_clean_word();
    test_correct();
    test_pass_done();
    test_host();
    test_saturate();
    test_reset_mid_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/hamming_scrub_ctrl.md
# hamming_scrub_ctrl

Background scrubber and access arbiter for a small memory of Hamming(7,4) codewords. It walks the memory address by address: read word, compute syndrome, write back the corrected word when a single-bit error is found. It also grants the memory port to a host requester, with host priority at word boundaries. It sits between the codeword RAM and the encoder/decoder datapath and tracks error statistics.

## Interface
- ADDR_W, 4, memory address width; the pass covers 2^ADDR_W words.
- INTERVAL, 16, idle cycles between consecutive word scrubs (≥1).
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scrubbing allowed; when low, no new word is started.
- host_req  in  1  host wants exclusive memory access.
- host_gnt  out  1  host owns the memory port; scrubber issues no accesses.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable (valid with mem_en).
- mem_addr  out  ADDR_W  access address.
- mem_wdata  out  7  corrected codeword.
- mem_rdata  in  7  read data, valid exactly 1 cycle after a read strobe.
- busy  out  1  scrubber mid-word (states RD, CHK, WB).
- pass_done  out  1  1-cycle pulse after the last address of a pass is checked.
- err_count  out  8  corrected-error count, saturates at 255.
- last_err_addr  out  ADDR_W  address of the most recent corrected word.

## Operation
- Codeword layout: c[0]=p1, c[1]=p2, c[2]=d0, c[3]=p4, c[4]=d1, c[5]=d2, c[6]=d3.
- Syndrome bits:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - s = {s4,s2,s1}
- s≠0: flip c[s-1] to form the corrected word.
- FSM states: IDLE, WAIT, RD, CHK, WB, HOST.
- IDLE: go to HOST if host_req; else go to WAIT if enable.
- WAIT: interval counter counts INTERVAL cycles.
  - host_req → HOST; the counter holds its value.
  - enable low → IDLE; the counter clears.
  - Counter expiry → RD.
- RD: one cycle, mem_en=1, mem_we=0, mem_addr=scrub pointer; → CHK.
- CHK: sample mem_rdata and compute s.
  - s=0 → NEXT action.
  - s≠0 → WB.
- WB: one cycle, mem_en=1, mem_we=1, mem_wdata=corrected word, same address.
  - err_count increments, saturating at 255.
  - last_err_addr ← pointer.
  - Then NEXT action.
- NEXT action, performed on leaving CHK/WB:
  - The pointer increments and wraps from 2^ADDR_W−1 to 0.
  - On wrap, pass_done pulses.
  - Next state is HOST if host_req, else WAIT with the counter cleared.
- HOST: host_gnt=1 and mem_* are driven 0. When host_req drops → WAIT with the counter resumed.
- host_req arriving during RD/CHK/WB does not abort the word; the grant is delayed until the word completes (≤3 cycles).
- Simultaneous host_req and counter expiry in WAIT: host wins.
- enable dropping mid-word: the current word completes, then → IDLE.

## Timing
- Reset values:
  - state=IDLE, pointer=0, counter=0
  - host_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, pass_done=0, err_count=0, last_err_addr=0
- All outputs are registered (Moore). host_gnt rises on the cycle after entry to HOST is decided, and falls on the cycle after host_req is sampled low.
- Clean word: RD→CHK = 2 cycles. Corrected word: 3 cycles.
- Word-to-word spacing with enable held and no host traffic:
  - Clean words: INTERVAL+2 cycles.
  - Corrected words: INTERVAL+3 cycles.
- A reset mid-WB aborts the write immediately; mem_en drops asynchronously.

## Test plan
- Word 0 preloaded with 7'b0101101 (data 0101), enable=1 → RD at addr 0; no write issued; err_count stays 0.
- Word 3 preloaded with 7'b0111101 (c[4] flipped) → s=101; WB writes 7'b0101101 to addr 3; err_count=1; last_err_addr=3.
- ADDR_W=4, all words clean → pass_done pulses exactly once per 16 words; pointer returns to 0.
- host_req asserted in the RD cycle → word finishes without a write; host_gnt=1 within 3 cycles; no mem_en while granted; scrubbing resumes at the next address after host_req drops.
- err_count preset near saturation via 256 injected errors → holds at 255.
- rst_n pulsed low during WB → all outputs take their reset values immediately; after release the scrub restarts at addr 0.
